// File: rtl/mod_mul_2_pkg.sv
// Shared arithmetic constants for the Kyber/Dilithium modular datapath stages.
// Also holds the mode encoding that travels with each operation.
package mod_mul_2_pkg;

    localparam int unsigned LAT  = 4;

    localparam int unsigned KQ_W = 12;
    localparam int unsigned DQ_W = 23;

    localparam logic [KQ_W-1:0] KQ = 12'd3329;
    localparam logic [DQ_W-1:0] DQ = 23'd8380417;

    // Barrett multipliers are floor(2^shift / q); shift covers the full product range
    localparam int unsigned    K_BM_W = 13;
    localparam logic [12:0]    K_BM   = 13'd5039;
    localparam int unsigned    K_BS   = 24;

    localparam int unsigned    D_BM_W = 24;
    localparam logic [23:0]    D_BM   = 24'd8396807;
    localparam int unsigned    D_BS   = 46;

    typedef enum logic {
        MODE_KYBER = 1'b0,
        MODE_DIL   = 1'b1
    } mode_e;

endpackage

// File: rtl/mod_mul_2_if.sv
// Operand/result bundle of the modular multiplier stage.
// The master side drives operands and observes results; the slave is the multiplier.
interface mod_mul_2_if #(
    parameter int unsigned TAG_W = 8
);
    logic             in_valid;
    logic             mode;
    logic [23:0]      mul_a;
    logic [23:0]      mul_b;
    logic [TAG_W-1:0] tag_in;

    logic             out_valid;
    logic [23:0]      mul_p;
    logic             out_mode;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, mode, mul_a, mul_b, tag_in,
        input  out_valid, mul_p, out_mode, tag_out
    );

    modport slave (
        input  in_valid, mode, mul_a, mul_b, tag_in,
        output out_valid, mul_p, out_mode, tag_out
    );
endinterface

// File: rtl/mod_mul_2_barrett_reduce.sv
// Two-stage Barrett reduction: registers the quotient estimate with the product,
// then corrects the remainder with up to two conditional subtractions of q.
module barrett_reduce #(
    parameter int unsigned    X_W = 24,
    parameter int unsigned    Q_W = 12,
    parameter int unsigned    M_W = 13,
    parameter int unsigned    K   = 24,
    parameter logic [Q_W-1:0] Q   = 12'd3329,
    parameter logic [M_W-1:0] M   = 13'd5039
) (
    input  logic           clk,
    input  logic           load,
    input  logic [X_W-1:0] x,
    output logic [Q_W-1:0] r
);
    localparam int unsigned P_W = X_W + M_W;
    localparam int unsigned E_W = P_W - K;
    // Estimate is low by at most 2, so the raw remainder fits below 4q
    localparam int unsigned R_W = Q_W + 2;

    logic [E_W-1:0] q_est;
    logic [E_W-1:0] q_est_r;
    logic [R_W-1:0] x_lo_r;
    logic [R_W-1:0] q_ext;
    logic [R_W-1:0] r0;
    logic [R_W-1:0] r1;
    logic [R_W-1:0] r2;

    always_comb begin
        q_est = E_W'((P_W'(x) * P_W'(M)) >> K);
    end

    always_ff @(posedge clk) begin
        if (load) begin
            q_est_r <= q_est;
            x_lo_r  <= x[R_W-1:0];
        end
    end

    always_comb begin
        q_ext = R_W'(Q);
        r0    = x_lo_r - (R_W'(q_est_r) * q_ext);
        r1    = (r0 >= q_ext) ? r0 - q_ext : r0;
        r2    = (r1 >= q_ext) ? r1 - q_ext : r1;
        r     = r2[Q_W-1:0];
    end

endmodule

// File: rtl/mod_mul_2.sv
// Four-stage modular multiplier: dual-lane mod 3329 (Kyber) or single-lane
// mod 8380417 (Dilithium), selected per operation, one operation per cycle.
module mod_mul_2 #(
    parameter int unsigned LAT   = mod_mul_2_pkg::LAT,
    parameter int unsigned TAG_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    mod_mul_2_if.slave bus
);
    import mod_mul_2_pkg::*;

    logic [LAT-1:0]   vld;

    mode_e            s1_mode;
    logic [TAG_W-1:0] s1_tag;
    logic [23:0]      s1_a;
    logic [23:0]      s1_b;

    mode_e            s2_mode;
    logic [TAG_W-1:0] s2_tag;
    logic [23:0]      p_hi;
    logic [23:0]      p_lo;
    logic [45:0]      p_dil;

    mode_e            s3_mode;
    logic [TAG_W-1:0] s3_tag;
    logic [KQ_W-1:0]  r_hi;
    logic [KQ_W-1:0]  r_lo;
    logic [DQ_W-1:0]  r_dil;

    logic [23:0]      p_q;
    mode_e            mode_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld <= {vld[LAT-2:0], bus.in_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            s1_mode <= mode_e'(bus.mode);
            s1_tag  <= bus.tag_in;
            s1_a    <= bus.mul_a;
            s1_b    <= bus.mul_b;
        end
    end

    always_ff @(posedge clk) begin
        if (vld[0]) begin
            s2_mode <= s1_mode;
            s2_tag  <= s1_tag;
            p_hi    <= 24'(s1_a[23:12]) * 24'(s1_b[23:12]);
            p_lo    <= 24'(s1_a[11:0]) * 24'(s1_b[11:0]);
            p_dil   <= 46'(s1_a[22:0]) * 46'(s1_b[22:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (vld[1]) begin
            s3_mode <= s2_mode;
            s3_tag  <= s2_tag;
        end
    end

    barrett_reduce #(
        .X_W (24),
        .Q_W (KQ_W),
        .M_W (K_BM_W),
        .K   (K_BS),
        .Q   (KQ),
        .M   (K_BM)
    ) u_red_hi (
        .clk  (clk),
        .load (vld[1]),
        .x    (p_hi),
        .r    (r_hi)
    );

    barrett_reduce #(
        .X_W (24),
        .Q_W (KQ_W),
        .M_W (K_BM_W),
        .K   (K_BS),
        .Q   (KQ),
        .M   (K_BM)
    ) u_red_lo (
        .clk  (clk),
        .load (vld[1]),
        .x    (p_lo),
        .r    (r_lo)
    );

    barrett_reduce #(
        .X_W (46),
        .Q_W (DQ_W),
        .M_W (D_BM_W),
        .K   (D_BS),
        .Q   (DQ),
        .M   (D_BM)
    ) u_red_dil (
        .clk  (clk),
        .load (vld[1]),
        .x    (p_dil),
        .r    (r_dil)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q    <= '0;
            mode_q <= MODE_KYBER;
            tag_q  <= '0;
        end else if (vld[2]) begin
            p_q    <= (s3_mode == MODE_DIL) ? {1'b0, r_dil} : {r_hi, r_lo};
            mode_q <= s3_mode;
            tag_q  <= s3_tag;
        end
    end

    assign bus.out_valid = vld[LAT-1];
    assign bus.mul_p     = p_q;
    assign bus.out_mode  = mode_q;
    assign bus.tag_out   = tag_q;

endmodule

// File: tb/tb_mod_mul_2.sv
// Scoreboard bench for mod_mul_2: expected results queued at issue, compared on
// emergence, with latency, hold-while-idle and reset discard behaviour checked.
module tb_mod_mul_2;

    localparam int unsigned TAG_W = 8;
    localparam int          DLY   = 4;

    typedef struct {
        int          due;
        logic        m;
        logic [7:0]  t;
        logic [23:0] p;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        rst_q;
    int          cyc;
    int          n_checks;
    int          n_errors;
    sb_t         sb[$];

    logic [23:0] hold_p;
    logic        hold_m;
    logic [7:0]  hold_t;

    mod_mul_2_if #(.TAG_W(TAG_W)) bus ();

    mod_mul_2 #(
        .LAT   (4),
        .TAG_W (TAG_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] ref_mul(input logic m, input logic [23:0] a, input logic [23:0] b);
        longint unsigned x;
        longint unsigned y;
        if (m) begin
            x = 64'(a[22:0]) * 64'(b[22:0]);
            x = x % 64'd8380417;
            return {1'b0, x[22:0]};
        end
        x = (64'(a[23:12]) * 64'(b[23:12])) % 64'd3329;
        y = (64'(a[11:0]) * 64'(b[11:0])) % 64'd3329;
        return {x[11:0], y[11:0]};
    endfunction

    task automatic drive(input logic r, input logic v, input logic m,
                         input logic [23:0] a, input logic [23:0] b, input logic [7:0] t);
        sb_t e;
        rst          = r;
        bus.in_valid = v;
        bus.mode     = m;
        bus.mul_a    = a;
        bus.mul_b    = b;
        bus.tag_in   = t;
        if (r) begin
            // Anything not already on the outputs is lost at the reset edge
            while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
        end else if (v) begin
            e.due = cyc + DLY;
            e.m   = m;
            e.t   = t;
            e.p   = ref_mul(m, a, b);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (rst_q === 1'b1) begin
            hold_p = '0;
            hold_m = 1'b0;
            hold_t = '0;
        end
        if (bus.out_valid === 1'b1) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("mul_p", 64'(bus.mul_p), 64'(e.p));
                check("out_mode", 64'(bus.out_mode), 64'(e.m));
                check("tag_out", 64'(bus.tag_out), 64'(e.t));
                hold_p = e.p;
                hold_m = e.m;
                hold_t = e.t;
            end else begin
                check("spurious_valid", 64'(bus.out_valid), 64'd0);
            end
        end else begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                check("missing_valid", 64'(bus.out_valid), 64'd1);
                void'(sb.pop_front());
            end
            if (rst_q !== 1'bx) begin
                check("hold", {31'd0, bus.out_mode, bus.tag_out, bus.mul_p},
                              {31'd0, hold_m, hold_t, hold_p});
            end
        end
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        cyc          = 0;
        hold_p       = '0;
        hold_m       = 1'b0;
        hold_t       = '0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.mode     = 1'b0;
        bus.mul_a    = '0;
        bus.mul_b    = '0;
        bus.tag_in   = '0;
        repeat (3) @(posedge clk);
        #1;

        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mul_p", 64'(bus.mul_p), 64'd0);
        check("rst_out_mode", 64'(bus.out_mode), 64'd0);
        check("rst_tag_out", 64'(bus.tag_out), 64'd0);

        // Corner vectors: ops start in the first cycle rst is low
        drive(1'b0, 1'b1, 1'b0, {12'd3328, 12'd17}, {12'd3328, 12'd17}, 8'h5A);
        drive(1'b0, 1'b1, 1'b0, {12'd4095, 12'd4095}, {12'd4095, 12'd4095}, 8'h11);
        drive(1'b0, 1'b1, 1'b1, 24'h400000, 24'h000002, 8'h22);
        drive(1'b0, 1'b1, 1'b1, 24'd8380416, 24'd8380416, 8'h33);
        drive(1'b0, 1'b1, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 8'h44);
        drive(1'b0, 1'b1, 1'b0, {12'd3329, 12'd0}, {12'd1, 12'd4095}, 8'h55);
        idle(6);

        // Alternating modes, bubble in the fourth slot
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, (i != 3), i[0], 24'($urandom), 24'($urandom), 8'(8'h80 + i));
        end
        idle(6);

        // Reset while three ops are in flight; next op follows immediately
        drive(1'b0, 1'b1, 1'b0, {12'd100, 12'd200}, {12'd300, 12'd400}, 8'hA1);
        drive(1'b0, 1'b1, 1'b1, 24'd123456, 24'd654321, 8'hA2);
        drive(1'b1, 1'b1, 1'b0, {12'd7, 12'd9}, {12'd11, 12'd13}, 8'hA3);
        check("rst_flight_valid", 64'(bus.out_valid), 64'd0);
        check("rst_flight_mul_p", 64'(bus.mul_p), 64'd0);
        check("rst_flight_mode", 64'(bus.out_mode), 64'd0);
        check("rst_flight_tag", 64'(bus.tag_out), 64'd0);
        drive(1'b0, 1'b1, 1'b1, 24'd8000000, 24'd7999999, 8'hA4);
        idle(6);

        // Random mixed traffic with occasional bubbles and near-modulus operands
        for (int i = 0; i < 4000; i++) begin
            logic [23:0] a;
            logic [23:0] b;
            logic        m;
            m = 1'($urandom);
            a = 24'($urandom);
            b = 24'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                a = m ? 24'(8380417 - $urandom_range(0, 3)) : {12'(3329 - $urandom_range(0, 2)), 12'd3328};
            end
            drive(1'b0, ($urandom_range(0, 9) != 0), m, a, b, 8'($urandom));
        end
        idle(8);

        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mod_mul_2.md
MOD_MUL_2 -- requirements
Module: mod_mul_2

Interface
REQ-001 SHALL have parameter LAT, default 4, meaning fixed input-to-output latency in cycles; only value 4 is supported.
REQ-002 SHALL have parameter TAG_W, default 8, meaning width of the sideband tag carried alongside each operation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand pair present this cycle.
REQ-006 mode  input  1  0 = Kyber dual-lane 12-bit, 1 = Dilithium single-lane 23-bit.
REQ-007 mul_a  input  24  operand A; Kyber {hi lane, lo lane} = [23:12],[11:0]; Dilithium uses [22:0].
REQ-008 mul_b  input  24  operand B, same packing as mul_a.
REQ-009 tag_in  input  TAG_W  sideband tag, passed through unchanged.
REQ-010 out_valid  output  1  product present on mul_p this cycle.
REQ-011 mul_p  output  24  modular product, same packing as the operands; feeds the Adder2_b operand of the downstream add/sub stage.
REQ-012 out_mode  output  1  mode of the operation on mul_p.
REQ-013 tag_out  output  TAG_W  tag of the operation on mul_p.

Function
REQ-014 Kyber mode SHALL give mul_p[23:12] = (a[23:12]*b[23:12]) mod 3329 and mul_p[11:0] = (a[11:0]*b[11:0]) mod 3329, fully reduced to 0..3328, for every 12-bit operand value including 3329..4095.
REQ-015 Dilithium mode SHALL give mul_p = {1'b0, (a[22:0]*b[22:0]) mod 8380417}, fully reduced to 0..8380416, for every 23-bit operand value; a[23] and b[23] are ignored.
REQ-016 Reduction SHALL be Barrett: a quotient estimate followed by at most two conditional subtractions of q; no division operators.
REQ-017 Pipeline SHALL be fully pipelined: one operation accepted per cycle, no stall, no backpressure input.
REQ-018 Pipeline stages: S1 register operands/mode/tag; S2 register raw products (two 24-bit or one 46-bit); S3 register quotient estimate and product; S4 register final reduced result.
REQ-019 out_valid SHALL equal in_valid delayed by exactly LAT cycles; mul_p/out_mode/tag_out SHALL correspond to the same accepted operation.
REQ-020 mode SHALL be sampled per operation and carried per stage; mixed Kyber/Dilithium back-to-back streams SHALL produce correct results with no bubble.
REQ-021 Stage data registers SHALL load only when that stage's valid bit is 1; while out_valid is 0, mul_p, out_mode and tag_out SHALL hold their last values.
REQ-022 A valid bubble at the input SHALL propagate as out_valid = 0 exactly LAT cycles later; there is no reordering.

Reset
REQ-023 While rst = 1 at a clock edge, all stage valid bits, out_valid, mul_p, out_mode and tag_out SHALL become 0.
REQ-024 Operations in flight when rst asserts SHALL be discarded; no out_valid pulse SHALL be produced for them after reset deasserts.
REQ-025 An operation presented in the cycle rst deasserts (rst = 0 at that edge) SHALL be accepted and SHALL emerge LAT cycles later.

Structure
REQ-026 Constants KQ = 3329, DQ = 8380417, the Barrett multipliers and shift amounts for both moduli, and LAT SHALL live in the shared arithmetic package used by the add/sub stages.
REQ-027 One sub-module, barrett_reduce, SHALL be parameterised by modulus width and constants; it is instantiated twice for the Kyber lanes and once for Dilithium, or is shared by muxing lane 0 with the 23-bit path.

Verification
REQ-028 Kyber corner: mode = 0, a = {3328,17}, b = {3328,17}, tag 0x5A -> 4 cycles later mul_p = 0x001121, out_mode = 0, tag_out = 0x5A.
REQ-029 Kyber out-of-range: a = b = {4095,4095} -> mul_p = {852,852} = 0x354354.
REQ-030 Dilithium: a = 0x400000, b = 0x000002 -> mul_p = 0x001FFF; a = b = 8380416 -> mul_p = 0x000001.
REQ-031 Streaming: 8 back-to-back ops alternating modes with a bubble at op 4 -> out_valid pattern equals the input pattern shifted by 4; every result matches the reference model.
REQ-032 Reset mid-flight: 3 ops issued, rst asserted for 1 cycle after op 2 -> no out_valid for ops 1-3, all outputs 0; an op issued the first cycle after reset emerges 4 cycles later.
REQ-033 Random: 10^5 random operands per mode against a golden model -> zero mismatches; every result is below q.
